// File: rtl/grf_pkg.sv
// Shared constants for the multi-port general register file with busy scoreboard.
package grf_pkg;
    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int REG_ZERO = 0;
    localparam int NREG     = 2 ** AW_DEF;
endpackage

// File: rtl/grf_rd_port.sv
// One combinational read port: optional write-to-read bypass plus busy lookup.
module grf_rd_port
    import grf_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     regs [2**AW],
    input  logic [2**AW-1:0]  busy_vec,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DW-1:0]     wd,
    output logic [DW-1:0]     data,
    output logic              busy
);

    always_comb begin
        data = regs[addr];
        busy = busy_vec[addr];
        if (BYPASS != 0 && we && wa == addr) begin
            data = wd;
            busy = 1'b0;
        end
        // Register 0 is hard-wired, independent of what storage holds.
        if (addr == AW'(REG_ZERO)) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/grf_mp.sv
// General register file with NRD read ports, per-register busy scoreboard and busy count.
module grf_mp
    import grf_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DW-1:0]     wd,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    output logic [AW:0]       busy_cnt
);

    localparam int NREGS = 2 ** AW;

    logic [DW-1:0]    regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    function automatic logic [AW:0] popcnt(input logic [NREGS-1:0] v);
        logic [AW:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + (AW+1)'(v[i]);
        end
        return cnt;
    endfunction

    // Issue is applied after write so a same-cycle new producer keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (we && wa != AW'(REG_ZERO)) begin
                busy_nxt[wa] = 1'b0;
            end
            if (iss_en && iss_addr != AW'(REG_ZERO)) begin
                busy_nxt[iss_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= popcnt(busy_nxt);
            if (we && wa != AW'(REG_ZERO)) begin
                regs[wa] <= wd;
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        grf_rd_port #(
            .DW     (DW),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rd (
            .addr     (rd_addr[g*AW +: AW]),
            .regs     (regs),
            .busy_vec (busy),
            .we       (we),
            .wa       (wa),
            .wd       (wd),
            .data     (rd_data[g*DW +: DW]),
            .busy     (rd_busy[g])
        );
    end

endmodule

// File: tb/tb_grf_mp.sv
// Directed bench for grf_mp: a bypassing 4-port instance and a non-bypassing 2-port instance.
module tb_grf_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [4*AW-1:0] rd_addr;
    logic [4*DW-1:0] rd_data1;
    logic [3:0]      rd_busy1;
    logic [2*DW-1:0] rd_data0;
    logic [1:0]      rd_busy0;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic          flush;
    logic [AW:0]   busy_cnt1;
    logic [AW:0]   busy_cnt0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    grf_mp #(.DW(DW), .AW(AW), .NRD(4), .BYPASS(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data1),
        .rd_busy  (rd_busy1),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt1)
    );

    grf_mp #(.DW(DW), .AW(AW), .NRD(2), .BYPASS(0)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr[2*AW-1:0]),
        .rd_data  (rd_data0),
        .rd_busy  (rd_busy0),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt0)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          iss;
        logic [AW-1:0] ia;
        logic          fl;
        logic [AW-1:0] ra;
        int            port;
        logic [DW-1:0] ed;
        logic          eb;
        int            ec;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    function automatic vec_t mk(input logic w, input int a, input logic [DW-1:0] d,
                                input logic i, input int ia, input logic f,
                                input int ra, input int p, input logic [DW-1:0] ed,
                                input logic eb, input int ec);
        vec_t v;
        v.we = w; v.wa = AW'(a); v.wd = d; v.iss = i; v.ia = AW'(ia); v.fl = f;
        v.ra = AW'(ra); v.port = p; v.ed = ed; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    initial begin
        // Each row: drive, check combinational outputs before the edge, then clock.
        tbl[0]  = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        tbl[1]  = mk(0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h0, 0, 0);
        tbl[2]  = mk(1, 8, 32'hDEAD_BEEF, 0, 0, 0, 8, 1, 32'hDEAD_BEEF, 0, 0);
        tbl[3]  = mk(0, 0, 32'h0,         0, 0, 0, 8, 0, 32'hDEAD_BEEF, 0, 0);
        tbl[4]  = mk(0, 0, 32'h0,         1, 3, 0, 3, 0, 32'h0, 0, 0);
        tbl[5]  = mk(0, 0, 32'h0,         0, 0, 0, 3, 0, 32'h0, 1, 1);
        tbl[6]  = mk(1, 3, 32'h55,        0, 0, 0, 3, 2, 32'h55, 0, 1);
        tbl[7]  = mk(0, 0, 32'h0,         0, 0, 0, 3, 2, 32'h55, 0, 0);
        tbl[8]  = mk(0, 0, 32'h0,         1, 7, 0, 7, 0, 32'h0, 0, 0);
        tbl[9]  = mk(1, 7, 32'hA5,        1, 7, 0, 7, 3, 32'hA5, 0, 1);
        tbl[10] = mk(0, 0, 32'h0,         0, 0, 0, 7, 3, 32'hA5, 1, 1);
        tbl[11] = mk(1, 7, 32'hA5,        0, 0, 0, 7, 3, 32'hA5, 0, 1);
        tbl[12] = mk(0, 0, 32'h0,         1, 2, 0, 2, 0, 32'h0, 0, 0);
        tbl[13] = mk(0, 0, 32'h0,         1, 4, 0, 2, 0, 32'h0, 1, 1);
        tbl[14] = mk(0, 0, 32'h0,         1, 6, 0, 4, 1, 32'h0, 1, 2);
        tbl[15] = mk(0, 0, 32'h0,         0, 0, 0, 6, 1, 32'h0, 1, 3);
        tbl[16] = mk(1, 2, 32'h77,        1, 9, 1, 9, 1, 32'h0, 0, 3);
        tbl[17] = mk(0, 0, 32'h0,         0, 0, 0, 9, 1, 32'h0, 0, 0);
        tbl[18] = mk(0, 0, 32'h0,         0, 0, 0, 2, 0, 32'h77, 0, 0);
        tbl[19] = mk(1, 1, 32'h11,        0, 0, 0, 1, 0, 32'h11, 0, 0);
        tbl[20] = mk(1, 2, 32'h22,        0, 0, 0, 2, 1, 32'h22, 0, 0);
        tbl[21] = mk(1, 3, 32'h33,        0, 0, 0, 3, 2, 32'h33, 0, 0);
        tbl[22] = mk(1, 4, 32'h44,        0, 0, 0, 4, 3, 32'h44, 0, 0);
        tbl[23] = mk(0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0, 0, 0);
        tbl[24] = mk(0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0, 0, 0);

        idle();
        rd_addr = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset clears a previously written register.
        we = 1'b1; wa = 5'd5; wd = 32'h1234;
        tick();
        idle();
        rd_addr = {4{5'd5}};
        #1;
        chk("pre_reset_rd5", rd_data1[0 +: DW], 32'h1234);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("reset_rd5_data", rd_data1[0 +: DW], 32'h0);
        chk("reset_rd5_busy", 32'(rd_busy1[0]), 32'h0);
        chk("reset_cnt", 32'(busy_cnt1), 32'h0);
        chk("reset_rd5_data_nobyp", rd_data0[0 +: DW], 32'h0);

        // No bypass: written value shows only after the edge; busy follows stored bit.
        we = 1'b1; wa = 5'd10; wd = 32'hCAFE_F00D;
        rd_addr = {4{5'd10}};
        #1;
        chk("nobyp_same_cycle", rd_data0[DW +: DW], 32'h0);
        chk("byp_same_cycle", rd_data1[DW +: DW], 32'hCAFE_F00D);
        tick();
        idle();
        #1;
        chk("nobyp_next_cycle", rd_data0[DW +: DW], 32'hCAFE_F00D);
        iss_en = 1'b1; iss_addr = 5'd11;
        tick();
        idle();
        we = 1'b1; wa = 5'd11; wd = 32'h0BAD;
        rd_addr = {4{5'd11}};
        #1;
        chk("nobyp_busy_during_wr", 32'(rd_busy0[1]), 32'h1);
        chk("nobyp_old_data", rd_data0[DW +: DW], 32'h0);
        chk("nobyp_cnt", 32'(busy_cnt0), 32'h1);
        tick();
        idle();
        #1;
        chk("nobyp_busy_after_wr", 32'(rd_busy0[1]), 32'h0);
        chk("nobyp_cnt_after", 32'(busy_cnt0), 32'h0);

        for (int k = 0; k < 25; k++) begin
            we = tbl[k].we; wa = tbl[k].wa; wd = tbl[k].wd;
            iss_en = tbl[k].iss; iss_addr = tbl[k].ia; flush = tbl[k].fl;
            rd_addr = {4{tbl[k].ra}};
            #1;
            chk($sformatf("row%0d_data", k), rd_data1[tbl[k].port*DW +: DW], tbl[k].ed);
            chk($sformatf("row%0d_busy", k), 32'(rd_busy1[tbl[k].port]), 32'(tbl[k].eb));
            chk($sformatf("row%0d_cnt", k), 32'(busy_cnt1), 32'(tbl[k].ec));
            tick();
        end
        idle();

        // All four ports on one address, then four distinct addresses.
        rd_addr = {4{5'd3}};
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("same_addr_p%0d", p), rd_data1[p*DW +: DW], 32'h33);
        end
        rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("distinct_p%0d", p), rd_data1[p*DW +: DW], 32'(8'h11 * (p + 1)));
        end

        // Reset wins over a same-cycle write and issue.
        we = 1'b1; wa = 5'd5; wd = 32'h99; iss_en = 1'b1; iss_addr = 5'd5;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        rd_addr = {4{5'd5}};
        #1;
        chk("rst_prio_data", rd_data1[0 +: DW], 32'h0);
        chk("rst_prio_busy", 32'(rd_busy1[0]), 32'h0);
        chk("rst_prio_cnt", 32'(busy_cnt1), 32'h0);
        rd_addr = {4{5'd3}};
        #1;
        chk("rst_clears_rd3", rd_data1[2*DW +: DW], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised successor to the current general register file for the pipelined MIPS core.
- Adds NRD independent combinational read ports, each with an optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard. Decode marks a destination busy at issue; writeback clears it.
- Sits between decode (reads, issue) and writeback (write); the hazard unit consumes rd_busy for stall decisions.

Parameters:
- DW, 32, data width of each register.
- AW, 5, address width; the file holds 2**AW registers.
- NRD, 2, number of read ports (legal range 1..4).
- BYPASS, 1, 1 = write data is forwarded to same-cycle reads of the written address; 0 = reads return stored value only.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all registers and busy bits.
- rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW].
- rd_data  out  NRD*DW  read data, port i at bits [i*DW +: DW].
- rd_busy  out  NRD  1 = port i's register has an outstanding producer.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  DW  write data.
- iss_en  in  1  issue strobe; marks iss_addr busy.
- iss_addr  in  AW  destination register of the issuing instruction.
- flush  in  1  clears all busy bits (pipeline squash); register contents are unaffected.
- busy_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: all 2**AW registers = 0 and all busy bits = 0 at the first rising edge with reset=1. Until then outputs reflect prior state. reset overrides we, iss_en and flush in the same cycle.
- Register 0: reads always return 0, rd_busy=0. Writes to 0 are ignored. Issue to 0 is ignored; busy[0] stays 0.
- Read path is combinational, zero latency.
  - BYPASS=1 and we=1 and wa==rd_addr[i]!=0: rd_data[i]=wd and rd_busy[i]=0.
  - Otherwise: rd_data[i]=reg[rd_addr[i]] and rd_busy[i]=busy[rd_addr[i]].
  - BYPASS=0: the written value becomes visible the cycle after the edge; rd_busy[i] reflects the stored busy bit.
- Write: at posedge with we=1 and wa!=0, reg[wa] takes wd, and busy[wa] is cleared unless the same-cycle rule below applies.
- Issue: at posedge with iss_en=1 and iss_addr!=0, busy[iss_addr] is set to 1. Re-issuing to an already busy register leaves it busy; there is no counting.
- Same-cycle issue and write to the same address: the new producer wins and busy ends 1. The write data is still stored.
- flush=1: all busy bits = 0 next cycle. flush overrides iss_en in that cycle. A write in that cycle still updates the register.
- busy_cnt: population count of the busy bits, registered alongside them. It equals 0 after reset and flush, and its maximum is 2**AW-1.
- Reads from multiple ports of the same address are legal and return identical data.
- All address inputs are fully decoded; no out-of-range case exists.

Decomposition:
- Shared package grf_pkg holds:
  - default DW/AW constants;
  - the REG_ZERO address constant;
  - the localparam NREG = 2**AW.
- Natural sub-module: grf_rd_port, one instance per read port (generate loop).
  - It contains the bypass compare/mux and the busy lookup.
  - It takes BYPASS as a parameter.
- Storage, scoreboard and popcount stay in the top module.

Test Plan:
- Reset and register 0:
  - Assert reset 1 cycle after writing reg 5 = 0x1234; then read port0=5 -> rd_data=0, rd_busy=0, busy_cnt=0.
  - With we=1, wa=0, wd=0xFFFFFFFF, then read 0 -> 0.
- Bypass:
  - BYPASS=1: we=1, wa=8, wd=0xDEADBEEF, rd_addr port1=8 in the same cycle -> rd_data[1]=0xDEADBEEF immediately.
  - BYPASS=0: the same stimulus returns the old value (0) that cycle and 0xDEADBEEF the next cycle.
- Scoreboard:
  - iss_en to reg 3 -> next cycle rd_busy=1 for reads of 3 and busy_cnt=1.
  - Then we to reg 3 with 0x55 -> same-cycle read gives 0x55 with busy=0 (BYPASS=1); the cycle after, busy_cnt=0.
- Simultaneous issue and write:
  - With reg 7 busy, drive iss_en to 7 and we to 7 with 0xA5 in the same cycle -> reg7=0xA5, busy[7]=1, busy_cnt unchanged.
- Flush priority:
  - Issue regs 2, 4, 6 (busy_cnt=3).
  - Then drive flush=1 with iss_en to 9 and we to 2 with 0x77 -> next cycle busy_cnt=0, reg 9 not busy, reg2=0x77.
- Multi-port:
  - NRD=4, regs 1..4 = 0x11, 0x22, 0x33, 0x44, all ports read 3 -> every port returns 0x33.
  - Then ports read 1,2,3,4 -> 0x11, 0x22, 0x33, 0x44.
